// File: rtl/topk_pkg.sv
// Shared definitions for the streaming top-K tracker.
//   DEF_DATA_WIDTH / DEF_K : default sample width and tracked depth
//   sample_t               : sample type at the default width
//   wide_t                 : compare container; samples are extended into it before comparing
//   gt()                   : strict greater-than on pre-extended operands, signed or unsigned
package topk_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_K          = 4;
    // Widest sample the compare path handles.
    localparam int MAX_W          = 64;

    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;
    typedef logic [MAX_W-1:0]          wide_t;

    // Operands must already be sign- or zero-extended to MAX_W to match signed_mode.
    function automatic logic gt(input wide_t a, input wide_t b, input logic signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

endpackage

// File: rtl/topk_slot.sv
// One rank cell of the top-K insertion sorter (purely combinational).
//   val_i/occ_i       : this rank's current value and occupancy
//   up_val_i/up_occ_i : rank above (r-1); tie to 0 for rank 0
//   up_flag_i         : the incoming sample lands at rank r-1 or above
//   din_i             : incoming sample
//   val_nx_o/occ_nx_o : this rank's contents if the sample is accepted
//   flag_o            : the incoming sample lands at this rank or above
module topk_slot
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIGNED     = 0
) (
    input  logic [DATA_WIDTH-1:0] val_i,
    input  logic                  occ_i,
    input  logic [DATA_WIDTH-1:0] up_val_i,
    input  logic                  up_occ_i,
    input  logic                  up_flag_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] val_nx_o,
    output logic                  occ_nx_o,
    output logic                  flag_o
);

    wide_t din_w;
    wide_t val_w;
    logic  here;

    always_comb begin
        if (SIGNED != 0) begin
            din_w = wide_t'($signed(din_i));
            val_w = wide_t'($signed(val_i));
        end else begin
            din_w = wide_t'(din_i);
            val_w = wide_t'(val_i);
        end

        // Ranks are sorted descending with occupied ranks contiguous from 0, so this
        // condition is monotone across ranks: once true at rank r it is true below r too.
        // It therefore already means "insert at this rank or above" without chaining.
        // Strict compare places an equal sample below existing equals.
        here   = !occ_i || gt(din_w, val_w, SIGNED != 0);
        flag_o = here;

        if (up_flag_i) begin
            // Insert point is above: take the upper neighbour's contents.
            val_nx_o = up_val_i;
            occ_nx_o = up_occ_i;
        end else if (here) begin
            val_nx_o = din_i;
            occ_nx_o = 1'b1;
        end else begin
            val_nx_o = val_i;
            occ_nx_o = occ_i;
        end
    end

endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: holds the K largest samples seen since reset/clear, sorted
// descending (rank 0 = largest). One-cycle insertion sort across K slot cells.
//   clk, resetn : clock, asynchronous active-low reset
//   din_valid   : din carries a sample this cycle
//   din         : sample
//   clear       : synchronous flush of all ranks (wins over din_valid)
//   rank_sel    : rank presented on dout at the next edge
//   dout        : value of rank rank_sel after this edge's update (0 when empty)
//   dout_vld    : rank rank_sel is occupied
//   topk        : all ranks, rank r at [r*DATA_WIDTH +: DATA_WIDTH]; empty ranks read 0
//   count       : occupied ranks, saturating at K
module topk_tracker
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K          = DEF_K,
    parameter int SIGNED     = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      din_valid,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      clear,
    input  logic [$clog2(K)-1:0]      rank_sel,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_vld,
    output logic [K*DATA_WIDTH-1:0]   topk,
    output logic [$clog2(K+1)-1:0]    count
);

    localparam int RANK_W = $clog2(K);
    localparam int CNT_W  = $clog2(K+1);

    logic [DATA_WIDTH-1:0] val_q  [K];
    logic [DATA_WIDTH-1:0] val_d  [K];
    logic [DATA_WIDTH-1:0] val_nx [K];
    logic [DATA_WIDTH-1:0] up_val [K];
    logic [K-1:0]          occ_q;
    logic [K-1:0]          occ_d;
    logic [K-1:0]          occ_nx;
    logic [K-1:0]          up_occ;
    logic [K-1:0]          flag;
    logic [K-1:0]          up_flag;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  dout_vld_q;
    logic                  dout_vld_d;

    // Rank 0 has no upper neighbour: it sees an empty, never-inserting rank above.
    assign up_flag = {flag[K-2:0], 1'b0};
    assign up_occ  = {occ_q[K-2:0], 1'b0};

    always_comb begin
        up_val[0] = '0;
        for (int r = 1; r < K; r++) begin
            up_val[r] = val_q[r-1];
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_slot
        topk_slot #(
            .DATA_WIDTH (DATA_WIDTH),
            .SIGNED     (SIGNED)
        ) u_slot (
            .val_i     (val_q[r]),
            .occ_i     (occ_q[r]),
            .up_val_i  (up_val[r]),
            .up_occ_i  (up_occ[r]),
            .up_flag_i (up_flag[r]),
            .din_i     (din),
            .val_nx_o  (val_nx[r]),
            .occ_nx_o  (occ_nx[r]),
            .flag_o    (flag[r])
        );

        // Empty ranks hold 0 by construction, so topk needs no occupancy masking.
        assign topk[r*DATA_WIDTH +: DATA_WIDTH] = val_q[r];
    end

    always_comb begin
        val_d   = val_q;
        occ_d   = occ_q;
        count_d = count_q;

        if (clear) begin
            for (int r = 0; r < K; r++) begin
                val_d[r] = '0;
            end
            occ_d   = '0;
            count_d = '0;
        end else if (din_valid) begin
            val_d = val_nx;
            occ_d = occ_nx;
            // flag of the last rank means the sample was placed somewhere.
            if (flag[K-1] && (count_q != CNT_W'(K))) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // Output mux reads next state; a rank_sel matching no rank yields 0 / not valid.
        dout_d     = '0;
        dout_vld_d = 1'b0;
        for (int r = 0; r < K; r++) begin
            if (rank_sel == RANK_W'(r)) begin
                dout_d     = val_d[r];
                dout_vld_d = occ_d[r];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < K; r++) begin
                val_q[r] <= '0;
            end
            occ_q      <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            val_q      <= val_d;
            occ_q      <= occ_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign count    = count_q;

endmodule

// File: tb/tb_topk_tracker.sv
module tb_topk_tracker;
    import topk_pkg::*;

    localparam int W = 32;
    localparam int K = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          din_valid;
    logic [W-1:0]  din;
    logic          clear;
    logic [1:0]    rank_sel;

    logic [W-1:0]   dout_u,   dout_s;
    logic           vld_u,    vld_s;
    logic [K*W-1:0] topk_u,   topk_s;
    logic [2:0]     cnt_u,    cnt_s;

    always #5 clk = ~clk;

    topk_tracker #(.DATA_WIDTH(W), .K(K), .SIGNED(0)) u_dut_u (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
        .rank_sel(rank_sel), .dout(dout_u), .dout_vld(vld_u), .topk(topk_u), .count(cnt_u)
    );

    topk_tracker #(.DATA_WIDTH(W), .K(K), .SIGNED(1)) u_dut_s (
        .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clear(clear),
        .rank_sel(rank_sel), .dout(dout_s), .dout_vld(vld_s), .topk(topk_s), .count(cnt_s)
    );

    typedef struct {
        logic [K*W-1:0] topk_u;
        logic [K*W-1:0] topk_s;
        logic [2:0]     cnt_u;
        logic [2:0]     cnt_s;
        logic [W-1:0]   dout_u;
        logic [W-1:0]   dout_s;
        logic           vld_u;
        logic           vld_s;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: per-mode sorted list, m=0 unsigned, m=1 signed.
    sample_t m_val [2][K];
    int      m_n   [2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_n[m] = 0;
            for (int i = 0; i < K; i++) m_val[m][i] = '0;
        end
    endtask

    task automatic model_apply(input int m, input logic v, input sample_t d, input logic c);
        int p;
        logic bigger;
        if (c) begin
            m_n[m] = 0;
            for (int i = 0; i < K; i++) m_val[m][i] = '0;
        end else if (v) begin
            p = m_n[m];
            for (int i = m_n[m] - 1; i >= 0; i--) begin
                bigger = (m == 1) ? ($signed(d) > $signed(m_val[m][i])) : (d > m_val[m][i]);
                if (bigger) p = i;
            end
            if (p < K) begin
                for (int i = K - 1; i > p; i--) m_val[m][i] = m_val[m][i-1];
                m_val[m][p] = d;
                if (m_n[m] < K) m_n[m]++;
            end
        end
    endtask

    function automatic logic [K*W-1:0] model_topk(input int m);
        logic [K*W-1:0] t;
        for (int i = 0; i < K; i++) t[i*W +: W] = m_val[m][i];
        return t;
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic c, input logic [1:0] rs);
        exp_t e;
        exp_t g;
        din_valid = v;
        din       = d;
        clear     = c;
        rank_sel  = rs;
        model_apply(0, v, d, c);
        model_apply(1, v, d, c);
        e.topk_u = model_topk(0);
        e.topk_s = model_topk(1);
        e.cnt_u  = 3'(m_n[0]);
        e.cnt_s  = 3'(m_n[1]);
        e.vld_u  = (int'(rs) < m_n[0]);
        e.vld_s  = (int'(rs) < m_n[1]);
        e.dout_u = e.vld_u ? m_val[0][rs] : '0;
        e.dout_s = e.vld_s ? m_val[1][rs] : '0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        check("topk_u", 128'(topk_u), 128'(g.topk_u));
        check("topk_s", 128'(topk_s), 128'(g.topk_s));
        check("cnt_u",  128'(cnt_u),  128'(g.cnt_u));
        check("cnt_s",  128'(cnt_s),  128'(g.cnt_s));
        check("dout_u", 128'(dout_u), 128'(g.dout_u));
        check("dout_s", 128'(dout_s), 128'(g.dout_s));
        check("vld_u",  128'(vld_u),  128'(g.vld_u));
        check("vld_s",  128'(vld_s),  128'(g.vld_s));
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_topk_u"}, 128'(topk_u), 128'd0);
        check({tag, "_topk_s"}, 128'(topk_s), 128'd0);
        check({tag, "_cnt_u"},  128'(cnt_u),  128'd0);
        check({tag, "_cnt_s"},  128'(cnt_s),  128'd0);
        check({tag, "_dout_u"}, 128'(dout_u), 128'd0);
        check({tag, "_vld_u"},  128'(vld_u),  128'd0);
        check({tag, "_vld_s"},  128'(vld_s),  128'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        clear     = 1'b0;
        rank_sel  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        resetn = 1'b1;

        // Fill: 5,9,3,7 -> {9,7,5,3}
        cycle(1'b1, 32'd5, 1'b0, 2'd1);
        cycle(1'b1, 32'd9, 1'b0, 2'd1);
        cycle(1'b1, 32'd3, 1'b0, 2'd1);
        cycle(1'b1, 32'd7, 1'b0, 2'd1);
        check("t1_topk", 128'(topk_u), {32'd3, 32'd5, 32'd7, 32'd9});
        check("t1_cnt",  128'(cnt_u),  128'd4);
        check("t1_dout", 128'(dout_u), 128'd7);

        // Smaller than all when full: no change; 8 evicts 3.
        cycle(1'b1, 32'd1, 1'b0, 2'd3);
        check("t2_small", 128'(topk_u), {32'd3, 32'd5, 32'd7, 32'd9});
        cycle(1'b1, 32'd8, 1'b0, 2'd3);
        check("t2_topk", 128'(topk_u), {32'd5, 32'd7, 32'd8, 32'd9});
        check("t2_cnt",  128'(cnt_u),  128'd4);

        // Rank sweep with no input.
        for (int r = 0; r < K; r++) cycle(1'b0, 32'd0, 1'b0, 2'(r));

        // Duplicates.
        cycle(1'b0, 32'd0, 1'b1, 2'd3);
        cycle(1'b1, 32'd6, 1'b0, 2'd3);
        cycle(1'b1, 32'd6, 1'b0, 2'd3);
        cycle(1'b1, 32'd6, 1'b0, 2'd3);
        check("t3_topk", 128'(topk_u), {32'd0, 32'd6, 32'd6, 32'd6});
        check("t3_cnt",  128'(cnt_u),  128'd3);
        check("t3_vld",  128'(vld_u),  128'd0);

        // Signed vs unsigned ordering of -2, 5, -7.
        cycle(1'b0, 32'd0, 1'b1, 2'd0);
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 2'd0);
        cycle(1'b1, 32'd5,         1'b0, 2'd0);
        cycle(1'b1, 32'hFFFF_FFF9, 1'b0, 2'd0);
        check("t4_signed",   128'(topk_s), {32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd5});
        check("t4_unsigned", 128'(topk_u), {32'd0, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFE});
        check("t4_dout_s",   128'(dout_s), 128'd5);

        // Clear wins over a valid sample.
        cycle(1'b1, 32'd100, 1'b1, 2'd0);
        check("t5_topk", 128'(topk_u), 128'd0);
        check("t5_cnt",  128'(cnt_u),  128'd0);

        // Async reset between edges mid-stream.
        cycle(1'b1, 32'd10, 1'b0, 2'd0);
        cycle(1'b1, 32'd20, 1'b0, 2'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        #1;
        resetn = 1'b1;
        cycle(1'b1, 32'd4, 1'b0, 2'd0);
        check("t6_topk", 128'(topk_u), {32'd0, 32'd0, 32'd0, 32'd4});
        check("t6_cnt",  128'(cnt_u),  128'd1);
        check("t6_dout", 128'(dout_u), 128'd4);

        // Random stream with frequent ties, sign-bit values and occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] d;
            d = {($urandom_range(0, 1) != 0) ? 28'hFFF_FFFF : 28'h0, 4'($urandom_range(0, 15))};
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
